// File: rtl/bp_me_cfg_cmd_arbiter_pkg.sv
// Shared defaults and width helpers for the cfg command arbiter.
// The processor-config defaults stand in for the values bp_params_p would supply.
package bp_me_cfg_cmd_arbiter_pkg;

  localparam int cfg_msg_width_gp   = 64;
  localparam int cfg_max_credits_gp = 4;

  // Index width that never collapses to zero bits.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold the value n itself (a counter that reaches n).
  function automatic int width_of(input int n);
    return (n <= 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bp_me_cfg_cmd_arbiter_id_fifo.sv
// Small FIFO of requester ids. Each entry is the owner of one issued command,
// and the head entry is the owner of the next response.
module bp_me_cfg_cmd_arbiter_id_fifo
  import bp_me_cfg_cmd_arbiter_pkg::*;
#(
  parameter int els_p   = 2,
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic               yumi_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o
);
  localparam int ptr_w_lp = safe_clog2(els_p);
  localparam int cnt_w_lp = width_of(els_p);

  logic [width_p-1:0]  mem_q [els_p];
  logic [width_p-1:0]  mem_d [els_p];
  logic [ptr_w_lp-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;

  function automatic logic [ptr_w_lp-1:0] inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (v_i) begin
      mem_d[wr_q] = data_i;
      wr_d        = inc(wr_q);
    end
    if (yumi_i) rd_d = inc(rd_q);
    case ({v_i, yumi_i})
      2'b10:   cnt_d = cnt_q + cnt_w_lp'(1);
      2'b01:   cnt_d = cnt_q - cnt_w_lp'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
    mem_q <= mem_d;
  end

  assign v_o    = (cnt_q != '0);
  assign data_o = mem_q[rd_q];

endmodule

// File: rtl/bp_me_cfg_cmd_arbiter.sv
// Round-robin, credit-limited arbiter sharing one cfg io_cmd channel among num_req_p
// requesters; responses return in issue order to the requester that sent the command.
module bp_me_cfg_cmd_arbiter
  import bp_me_cfg_cmd_arbiter_pkg::*;
#(
  parameter int num_req_p     = 2,
  parameter int max_credits_p = cfg_max_credits_gp,
  parameter int msg_w_p       = cfg_msg_width_gp
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [num_req_p*msg_w_p-1:0] cmd_i,
  input  logic [num_req_p-1:0]         cmd_v_i,
  output logic [num_req_p-1:0]         cmd_yumi_o,
  output logic [msg_w_p-1:0]           resp_o,
  output logic [num_req_p-1:0]         resp_v_o,
  input  logic [num_req_p-1:0]         resp_ready_i,
  output logic [msg_w_p-1:0]           io_cmd_o,
  output logic                         io_cmd_v_o,
  input  logic                         io_cmd_yumi_i,
  input  logic [msg_w_p-1:0]           io_resp_i,
  input  logic                         io_resp_v_i,
  output logic                         io_resp_ready_o
);
  localparam int id_w_lp  = safe_clog2(num_req_p);
  localparam int cnt_w_lp = width_of(max_credits_p);

  localparam logic state_idle   = 1'b0;
  localparam logic state_locked = 1'b1;

  logic                state_q, state_d;
  logic [id_w_lp-1:0]  grant_q, grant_d, rr_q, rr_d;
  logic [id_w_lp-1:0]  idx, win, sel, head;
  logic [cnt_w_lp-1:0] credits_q, credits_d;
  logic                found, issue, fifo_v, pop;
  logic [msg_w_p-1:0]  cmd_arr [num_req_p];

  for (genvar i = 0; i < num_req_p; i++) begin : g_req
    assign cmd_arr[i] = cmd_i[i*msg_w_p +: msg_w_p];
  end

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < num_req_p; k++) begin
      idx = id_w_lp'((int'(rr_q) + k) % num_req_p);
      if (!found && cmd_v_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Full check uses the registered count, so a same-cycle return never enables an issue.
  always_comb begin
    sel        = (state_q == state_locked) ? grant_q : win;
    io_cmd_v_o = (state_q == state_locked) ||
                 (found && (credits_q < cnt_w_lp'(max_credits_p)));
    io_cmd_o   = io_cmd_v_o ? cmd_arr[sel] : '0;
    issue      = io_cmd_v_o && io_cmd_yumi_i;
    cmd_yumi_o = issue ? (num_req_p'(1) << sel) : '0;
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    if (issue) begin
      state_d = state_idle;
      rr_d    = (sel == id_w_lp'(num_req_p - 1)) ? '0 : sel + id_w_lp'(1);
    end else if (io_cmd_v_o && (state_q == state_idle)) begin
      state_d = state_locked;
      grant_d = sel;
    end
  end

  assign resp_o          = io_resp_i;
  assign io_resp_ready_o = fifo_v && resp_ready_i[head];
  assign resp_v_o        = (io_resp_v_i && fifo_v) ? (num_req_p'(1) << head) : '0;
  assign pop             = io_resp_v_i && io_resp_ready_o;

  always_comb begin
    credits_d = credits_q;
    case ({issue, pop})
      2'b10:   credits_d = credits_q + cnt_w_lp'(1);
      2'b01:   credits_d = credits_q - cnt_w_lp'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= state_idle;
      grant_q   <= '0;
      rr_q      <= '0;
      credits_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      credits_q <= credits_d;
    end
  end

  bp_me_cfg_cmd_arbiter_id_fifo #(
    .els_p   (max_credits_p),
    .width_p (id_w_lp)
  ) id_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (issue),
    .data_i  (sel),
    .yumi_i  (pop),
    .v_o     (fifo_v),
    .data_o  (head)
  );

  // A response with nothing outstanding must stall rather than be routed anywhere.
  assert property (@(posedge clk_i) disable iff (reset_i)
    (io_resp_v_i && !fifo_v) |-> (!io_resp_ready_o && (resp_v_o == '0)))
    else $error("stray io response was accepted or routed");

endmodule

// File: tb/tb_bp_me_cfg_cmd_arbiter.sv
// Bench for bp_me_cfg_cmd_arbiter: directed scenarios plus a randomized run against
// a queue-based reference model of arbitration, credits and response routing.
module tb_bp_me_cfg_cmd_arbiter;
  localparam int N  = 2;
  localparam int MC = 2;
  localparam int W  = 16;

  logic           clk, reset;
  logic [N*W-1:0] cmd;
  logic [W-1:0]   req_msg [N];
  logic [N-1:0]   cmd_v, cmd_yumi, resp_v, resp_ready;
  logic [W-1:0]   resp, io_cmd, io_resp;
  logic           io_cmd_v, io_cmd_yumi, io_resp_v, io_resp_ready;
  logic [21:0]    snap;

  int vectors, miscompares;
  int idq[$];

  assign cmd  = {req_msg[1], req_msg[0]};
  assign snap = {io_cmd_v, cmd_yumi, io_cmd, resp_v, io_resp_ready};

  bp_me_cfg_cmd_arbiter #(.num_req_p(N), .max_credits_p(MC), .msg_w_p(W)) dut (
    .clk_i(clk), .reset_i(reset), .cmd_i(cmd), .cmd_v_i(cmd_v), .cmd_yumi_o(cmd_yumi),
    .resp_o(resp), .resp_v_o(resp_v), .resp_ready_i(resp_ready),
    .io_cmd_o(io_cmd), .io_cmd_v_o(io_cmd_v), .io_cmd_yumi_i(io_cmd_yumi),
    .io_resp_i(io_resp), .io_resp_v_i(io_resp_v), .io_resp_ready_o(io_resp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [21:0] exp_of(input logic v, input logic [1:0] y,
      input logic [15:0] c, input logic [1:0] rv, input logic rr);
    return {v, y, c, rv, rr};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    req_msg[0] = '0; req_msg[1] = '0; cmd_v = '0; io_cmd_yumi = 1'b0;
    resp_ready = '0; io_resp_v = 1'b0; io_resp = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    vectors++;
    if (snap !== 22'h0) begin miscompares++; $display("FAIL reset_outputs: got %h want %h", snap, 22'h0); end
    vectors++;
    if (resp !== 16'h0) begin miscompares++; $display("FAIL reset_resp: got %h want %h", resp, 16'h0); end
    tick();
  endtask

  task automatic test_single_req();
    logic [21:0] e [6];
    apply_reset();
    e[0] = exp_of(1, 2'b01, 16'hA001, 2'b00, 0);
    e[1] = exp_of(1, 2'b01, 16'hA002, 2'b00, 0);
    e[2] = exp_of(0, 2'b00, 16'h0000, 2'b01, 1);
    e[3] = exp_of(1, 2'b01, 16'hA003, 2'b01, 1);
    e[4] = exp_of(0, 2'b00, 16'h0000, 2'b01, 1);
    e[5] = exp_of(0, 2'b00, 16'h0000, 2'b00, 0);
    for (int k = 0; k < 6; k++) begin
      cmd_v       = (k < 4) ? 2'b01 : 2'b00;
      req_msg[0]  = (k < 2) ? 16'hA001 + 16'(k) : 16'hA003;
      io_cmd_yumi = 1'b1;
      resp_ready  = (k >= 2) ? 2'b11 : 2'b00;
      io_resp_v   = (k >= 2 && k < 5);
      #1;
      vectors++;
      if (snap !== e[k]) begin miscompares++; $display("FAIL single_req[%0d]: got %h want %h", k, snap, e[k]); end
      tick();
    end
  endtask

  task automatic test_alternate();
    logic [21:0] e;
    int g;
    apply_reset();
    cmd_v = 2'b11; io_cmd_yumi = 1'b1; resp_ready = 2'b11;
    for (int k = 0; k < 6; k++) begin
      g          = k % 2;
      req_msg[0] = 16'hB000 + 16'(k);
      req_msg[1] = 16'hB100 + 16'(k);
      io_resp_v  = (k > 0);
      e = exp_of(1, 2'(1 << g), g ? req_msg[1] : req_msg[0],
                 (k > 0) ? 2'(1 << ((k - 1) % 2)) : 2'b00, k > 0);
      #1;
      vectors++;
      if (snap !== e) begin miscompares++; $display("FAIL alternate[%0d]: got %h want %h", k, snap, e); end
      tick();
    end
  endtask

  task automatic test_credit_limit();
    logic [21:0] e;
    int p;
    apply_reset();
    p = 0; cmd_v = 2'b01; io_cmd_yumi = 1'b1;
    for (int k = 0; k < 7; k++) begin
      req_msg[0] = 16'hC000 + 16'(p);
      io_resp_v  = (k == 4);
      resp_ready = (k == 4) ? 2'b11 : 2'b00;
      if (k < 2 || k == 5) e = exp_of(1, 2'b01, req_msg[0], 2'b00, 0);
      else if (k == 4)     e = exp_of(0, 2'b00, 16'h0, 2'b01, 1);
      else                 e = exp_of(0, 2'b00, 16'h0, 2'b00, 0);
      #1;
      vectors++;
      if (snap !== e) begin miscompares++; $display("FAIL credit_limit[%0d]: got %h want %h", k, snap, e); end
      if (k < 2 || k == 5) p++;
      tick();
    end
  endtask

  task automatic test_hold();
    logic [21:0] e [9];
    apply_reset();
    req_msg[1] = 16'hD111; req_msg[0] = 16'hD000;
    for (int k = 0; k < 6; k++) e[k] = exp_of(1, (k == 5) ? 2'b10 : 2'b00, 16'hD111, 2'b00, 0);
    e[6] = exp_of(1, 2'b01, 16'hD000, 2'b00, 0);
    e[7] = exp_of(0, 2'b00, 16'h0, 2'b10, 1);
    e[8] = exp_of(0, 2'b00, 16'h0, 2'b01, 1);
    for (int k = 0; k < 9; k++) begin
      cmd_v       = (k == 0) ? 2'b10 : (k < 6) ? 2'b11 : (k == 6) ? 2'b01 : 2'b00;
      io_cmd_yumi = (k == 5 || k == 6);
      io_resp_v   = (k >= 7);
      resp_ready  = (k >= 7) ? 2'b11 : 2'b00;
      #1;
      vectors++;
      if (snap !== e[k]) begin miscompares++; $display("FAIL hold[%0d]: got %h want %h", k, snap, e[k]); end
      tick();
    end
  endtask

  task automatic test_resp_backpressure();
    logic [21:0] e;
    apply_reset();
    for (int k = 0; k < 9; k++) begin
      cmd_v       = (k == 0) ? 2'b10 : (k >= 6 && k < 9) ? 2'b01 : 2'b00;
      req_msg[1]  = 16'hE111;
      req_msg[0]  = (k == 6) ? 16'hE000 : 16'hE001;
      io_cmd_yumi = 1'b1;
      io_resp_v   = (k >= 1 && k <= 5);
      resp_ready  = (k >= 1 && k <= 4) ? 2'b01 : (k == 5) ? 2'b11 : 2'b00;
      if (k == 0)      e = exp_of(1, 2'b10, 16'hE111, 2'b00, 0);
      else if (k <= 4) e = exp_of(0, 2'b00, 16'h0, 2'b10, 0);
      else if (k == 5) e = exp_of(0, 2'b00, 16'h0, 2'b10, 1);
      else if (k <= 7) e = exp_of(1, 2'b01, req_msg[0], 2'b00, 0);
      else             e = exp_of(0, 2'b00, 16'h0, 2'b00, 0);
      #1;
      vectors++;
      if (snap !== e) begin miscompares++; $display("FAIL resp_backpressure[%0d]: got %h want %h", k, snap, e); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [21:0] e;
    apply_reset();
    cmd_v = 2'b01; req_msg[0] = 16'hF000; io_cmd_yumi = 1'b1;
    tick();
    cmd_v = 2'b10; req_msg[1] = 16'hF111; io_cmd_yumi = 1'b0;
    #1;
    e = exp_of(1, 2'b00, 16'hF111, 2'b00, 0);
    vectors++;
    if (snap !== e) begin miscompares++; $display("FAIL reset_mid_locked: got %h want %h", snap, e); end
    tick();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    vectors++;
    if ({snap, resp} !== 38'h0) begin miscompares++; $display("FAIL reset_mid_outputs: got %h want %h", {snap, resp}, 38'h0); end
    io_resp_v = 1'b1; resp_ready = 2'b11;
    #1;
    vectors++;
    if (snap !== 22'h0) begin miscompares++; $display("FAIL reset_mid_stray: got %h want %h", snap, 22'h0); end
    tick();
    io_resp_v = 1'b0; resp_ready = 2'b00;
    cmd_v = 2'b11; req_msg[0] = 16'hF0A0; req_msg[1] = 16'hF1A1; io_cmd_yumi = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 0)      e = exp_of(1, 2'b01, 16'hF0A0, 2'b00, 0);
      else if (k == 1) e = exp_of(1, 2'b10, 16'hF1A1, 2'b00, 0);
      else             e = exp_of(0, 2'b00, 16'h0, 2'b00, 0);
      #1;
      vectors++;
      if (snap !== e) begin miscompares++; $display("FAIL reset_mid_credits[%0d]: got %h want %h", k, snap, e); end
      tick();
    end
  endtask

  task automatic test_random();
    bit          m_locked;
    int          m_grant, m_ptr, w, idx;
    bit          ev, er;
    logic [N-1:0] eyumi, erv, last_yumi;
    logic [W-1:0] ecmd;
    logic [21:0]  e;
    apply_reset();
    idq.delete();
    m_locked = 0; m_grant = 0; m_ptr = 0; last_yumi = '0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!cmd_v[i] || last_yumi[i]) begin
          cmd_v[i]   = ($urandom_range(2) != 0);
          req_msg[i] = W'($urandom);
        end
      end
      io_cmd_yumi = 1'($urandom_range(1));
      resp_ready  = N'($urandom_range(3));
      io_resp     = W'($urandom);
      io_resp_v   = (idq.size() > 0) && ($urandom_range(1) == 1);
      #1;
      // Reference: a held grant wins outright; otherwise first valid from the pointer if a credit is free.
      ev = 0; w = 0;
      if (m_locked) begin
        ev = 1; w = m_grant;
      end else if (idq.size() < MC) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (!ev && cmd_v[idx]) begin ev = 1; w = idx; end
        end
      end
      ecmd  = ev ? req_msg[w] : '0;
      eyumi = (ev && io_cmd_yumi) ? N'(1 << w) : '0;
      er    = (idq.size() > 0) && resp_ready[idq[0]];
      erv   = (io_resp_v && idq.size() > 0) ? N'(1 << idq[0]) : '0;
      e     = {ev, eyumi, ecmd, erv, er};
      vectors++;
      if (snap !== e) begin miscompares++; $display("FAIL random[%0d]: got %h want %h", cyc, snap, e); end
      vectors++;
      if (resp !== io_resp) begin miscompares++; $display("FAIL random_resp[%0d]: got %h want %h", cyc, resp, io_resp); end
      @(posedge clk);
      if (io_resp_v && er) void'(idq.pop_front());
      if (ev && io_cmd_yumi) begin
        idq.push_back(w);
        m_ptr    = (w + 1) % N;
        m_locked = 0;
      end else if (ev) begin
        m_locked = 1;
        m_grant  = w;
      end
      last_yumi = eyumi;
      #2;
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_req();
    test_alternate();
    test_credit_limit();
    test_hold();
    test_resp_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
